// File: rtl/gesture_pkg.sv
// ----------------------------------------------------------------------------
// gesture_pkg
// Definitions shared by the gesture command sequencer and its debouncer:
//   - gesture id codes delivered by the upstream classifier
//   - sequencer FSM state encoding
//   - default home angle and the joint index of the gripper
//   - width of the debounce streak counter
// ----------------------------------------------------------------------------
package gesture_pkg;

    // Gesture codes from the classifier. Codes above GID_GRIP are legal
    // inputs; they debounce normally but never trigger an action.
    localparam logic [7:0] GID_NONE       = 8'd0;
    localparam logic [7:0] GID_NEXT_JOINT = 8'd1;
    localparam logic [7:0] GID_INC        = 8'd2;
    localparam logic [7:0] GID_DEC        = 8'd3;
    localparam logic [7:0] GID_HOME       = 8'd4;
    localparam logic [7:0] GID_GRIP       = 8'd5;

    // Joint 3 is the gripper; it is driven only by the grip toggle.
    localparam logic [1:0] GRIPPER_JOINT = 2'd3;

    // Home position that every joint returns to on reset.
    localparam logic [7:0] HOME_ANGLE_DEFAULT = 8'd90;

    // Streak counter width; holds STABLE_FRAMES values up to 15.
    localparam int STREAK_W = 4;

    // IDLE : gestures are accepted and debounced
    // EXEC : one cycle in which the qualified action updates the joint state
    // SEND : command presented downstream, waiting for cmd_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SEND = 2'd2
    } seq_state_e;

    // True for the ids that move the sequencer out of IDLE once qualified.
    function automatic logic is_action_id(input logic [7:0] id);
        return (id >= GID_NEXT_JOINT) && (id <= GID_GRIP);
    endfunction

endpackage

// File: rtl/gesture_debouncer.sv
// ----------------------------------------------------------------------------
// gesture_debouncer
// Requires STABLE_FRAMES consecutive accepted gestures with the same id
// before declaring that id qualified. Qualification fires only on the
// accept that brings the streak up to STABLE_FRAMES; further identical ids
// keep the streak saturated and do not re-fire until a different id has
// been accepted.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   accept_i   in   gesture accepted this cycle (already gated by the FSM)
//   id_i       in   gesture id belonging to accept_i
//   qualify_o  out  one-cycle pulse, high in the accepting cycle itself
//   qual_id_o  out  id that qualified, valid while qualify_o is high
// ----------------------------------------------------------------------------
module gesture_debouncer
    import gesture_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept_i,
    input  logic [7:0] id_i,
    output logic       qualify_o,
    output logic [7:0] qual_id_o
);

    localparam logic [STREAK_W-1:0] STABLE = STREAK_W'(STABLE_FRAMES);
    localparam logic [STREAK_W-1:0] ONE    = STREAK_W'(1);

    logic [7:0]          cand_q,   cand_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    // Qualification is combinational so the sequencer can leave IDLE on the
    // same edge that completes the streak.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        cand_d    = cand_q;
        streak_d  = streak_q;
        qualify_o = 1'b0;

        if (accept_i) begin
            if (id_i == cand_q) begin
                // Saturated streak stays put, which is what stops a held
                // gesture from firing again.
                if (streak_q != STABLE) begin
                    streak_d  = streak_q + ONE;
                    qualify_o = (streak_d == STABLE);
                end
            end else begin
                cand_d    = id_i;
                streak_d  = ONE;
                qualify_o = (STABLE == ONE);
            end
        end
    end

    assign qual_id_o = id_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q   <= GID_NONE;
            streak_q <= '0;
        end else begin
            cand_q   <= cand_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/gesture_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// gesture_cmd_sequencer
// Turns debounced hand gestures into servo commands for a 4-joint arm
// (joints 0..2 plus the gripper on joint 3). A per-joint angle table is
// kept in flops; each qualified action updates the table and, except for
// joint selection, presents a valid/ready command downstream.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   gesture_valid  in   one-cycle pulse, gesture_id valid with it
//   gesture_id     in   gesture code (0..5 defined)
//   cmd_valid      out  servo command available
//   cmd_ready      in   downstream accepts when cmd_valid && cmd_ready
//   cmd_joint      out  joint addressed by the command (3 = gripper)
//   cmd_angle      out  target angle for cmd_joint
//   joint_sel      out  currently selected joint
//   drop_pulse     out  one-cycle pulse when a gesture arrives while busy
//
// Timing: the edge that qualifies a gesture moves IDLE->EXEC; the next edge
// writes the angle table and the command registers and raises cmd_valid.
// cmd_joint/cmd_angle stay frozen until the handshake completes.
// ----------------------------------------------------------------------------
module gesture_cmd_sequencer
    import gesture_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter logic [7:0]  STEP          = 8'd4,
    parameter logic [7:0]  ANGLE_MIN     = 8'd0,
    parameter logic [7:0]  ANGLE_MAX     = 8'd180,
    parameter logic [7:0]  HOME_ANGLE    = HOME_ANGLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gesture_valid,
    input  logic [7:0] gesture_id,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_joint,
    output logic [7:0] cmd_angle,
    output logic [1:0] joint_sel,
    output logic       drop_pulse
);

    seq_state_e       state_q,     state_d;
    logic [7:0]       exec_id_q,   exec_id_d;
    logic [3:0][7:0]  angle_q,     angle_d;
    logic [1:0]       joint_sel_q, joint_sel_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_joint_q, cmd_joint_d;
    logic [7:0]       cmd_angle_q, cmd_angle_d;
    logic             drop_q,      drop_d;

    logic             accept;
    logic             qualify;
    logic [7:0]       qual_id;

    logic [7:0]       cur_angle;
    logic [8:0]       inc_sum;
    logic [7:0]       inc_angle;
    logic [7:0]       dec_angle;
    logic [7:0]       grip_angle;

    // Gestures are only fed to the debouncer while idle; anything arriving
    // in EXEC or SEND is dropped and leaves the debouncer untouched.
    assign accept = gesture_valid && (state_q == ST_IDLE);

    gesture_debouncer #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .id_i      (gesture_id),
        .qualify_o (qualify),
        .qual_id_o (qual_id)
    );

    // Candidate angles for the selected joint. The arithmetic is done one
    // bit wider so an overflow past 255 or a borrow below 0 is caught before
    // clamping to the joint limits.
    always_comb begin
        cur_angle = angle_q[joint_sel_q];
        inc_sum   = {1'b0, cur_angle} + {1'b0, STEP};
        inc_angle = (inc_sum > {1'b0, ANGLE_MAX}) ? ANGLE_MAX : inc_sum[7:0];

        if ({1'b0, cur_angle} < ({1'b0, STEP} + {1'b0, ANGLE_MIN})) begin
            dec_angle = ANGLE_MIN;
        end else begin
            dec_angle = cur_angle - STEP;
        end

        grip_angle = (angle_q[GRIPPER_JOINT] != ANGLE_MAX) ? ANGLE_MAX : ANGLE_MIN;
    end

    always_comb begin
        state_d     = state_q;
        exec_id_d   = exec_id_q;
        angle_d     = angle_q;
        joint_sel_d = joint_sel_q;
        cmd_valid_d = cmd_valid_q;
        cmd_joint_d = cmd_joint_q;
        cmd_angle_d = cmd_angle_q;
        drop_d      = gesture_valid && (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                // Ids 0 and >5 still qualify in the debouncer but are
                // ignored here, so they never produce a command.
                if (qualify && is_action_id(qual_id)) begin
                    state_d   = ST_EXEC;
                    exec_id_d = qual_id;
                end
            end

            ST_EXEC: begin
                case (exec_id_q)
                    GID_NEXT_JOINT: begin
                        joint_sel_d = joint_sel_q + 2'd1;
                        state_d     = ST_IDLE;
                    end
                    GID_INC: begin
                        angle_d[joint_sel_q] = inc_angle;
                        cmd_joint_d          = joint_sel_q;
                        cmd_angle_d          = inc_angle;
                        cmd_valid_d          = 1'b1;
                        state_d              = ST_SEND;
                    end
                    GID_DEC: begin
                        angle_d[joint_sel_q] = dec_angle;
                        cmd_joint_d          = joint_sel_q;
                        cmd_angle_d          = dec_angle;
                        cmd_valid_d          = 1'b1;
                        state_d              = ST_SEND;
                    end
                    GID_HOME: begin
                        angle_d[joint_sel_q] = HOME_ANGLE;
                        cmd_joint_d          = joint_sel_q;
                        cmd_angle_d          = HOME_ANGLE;
                        cmd_valid_d          = 1'b1;
                        state_d              = ST_SEND;
                    end
                    GID_GRIP: begin
                        // The gripper toggles regardless of joint_sel.
                        angle_d[GRIPPER_JOINT] = grip_angle;
                        cmd_joint_d            = GRIPPER_JOINT;
                        cmd_angle_d            = grip_angle;
                        cmd_valid_d            = 1'b1;
                        state_d                = ST_SEND;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_SEND: begin
                // Command fields are not touched here, so they hold steady
                // for as long as the downstream stalls.
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of the others, independent of order.
        if (rst) begin
            state_q     <= ST_IDLE;
            exec_id_q   <= GID_NONE;
            // NOTE: the angle table is plain flops, not a RAM, so every entry
            // can be (and is) reset to home in one cycle.
            angle_q     <= {4{HOME_ANGLE}};
            joint_sel_q <= 2'd0;
            cmd_valid_q <= 1'b0;
            cmd_joint_q <= 2'd0;
            cmd_angle_q <= 8'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exec_id_q   <= exec_id_d;
            angle_q     <= angle_d;
            joint_sel_q <= joint_sel_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_joint_q <= cmd_joint_d;
            cmd_angle_q <= cmd_angle_d;
            drop_q      <= drop_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_joint  = cmd_joint_q;
    assign cmd_angle  = cmd_angle_q;
    assign joint_sel  = joint_sel_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_gesture_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gesture_cmd_sequencer
// Directed stimulus for gesture_cmd_sequencer with default parameters.
// A behavioural model (streak counting on integers, an integer angle table,
// and a busy/pending notion instead of FSM states) predicts the outputs
// every cycle; literal expectations pin the key scenarios.
// ----------------------------------------------------------------------------
module tb_gesture_cmd_sequencer;

    localparam int S     = 3;
    localparam int STEP  = 4;
    localparam int AMIN  = 0;
    localparam int AMAX  = 180;
    localparam int HOME  = 90;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gesture_valid = 1'b0;
    logic [7:0] gesture_id = 8'd0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_joint;
    logic [7:0] cmd_angle;
    logic [1:0] joint_sel;
    logic       drop_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gesture_cmd_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .gesture_valid (gesture_valid),
        .gesture_id    (gesture_id),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_joint     (cmd_joint),
        .cmd_angle     (cmd_angle),
        .joint_sel     (joint_sel),
        .drop_pulse    (drop_pulse)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_cand   = 0;
    int  m_streak = 0;
    int  m_sel    = 0;
    int  m_pend   = -1;     // action waiting to execute next edge, -1 = none
    int  m_ang [4] = '{HOME, HOME, HOME, HOME};
    bit  m_valid  = 1'b0;
    int  m_joint  = 0;
    int  m_angle  = 0;
    bit  m_drop   = 1'b0;
    bit  started  = 1'b0;

    task automatic model_apply(input int id);
        int a;
        case (id)
            1: m_sel = (m_sel + 1) % 4;
            2: begin
                a = m_ang[m_sel] + STEP;
                if (a > AMAX) a = AMAX;
                m_ang[m_sel] = a; m_joint = m_sel; m_angle = a; m_valid = 1'b1;
            end
            3: begin
                a = m_ang[m_sel] - STEP;
                if (a < AMIN) a = AMIN;
                m_ang[m_sel] = a; m_joint = m_sel; m_angle = a; m_valid = 1'b1;
            end
            4: begin
                m_ang[m_sel] = HOME; m_joint = m_sel; m_angle = HOME; m_valid = 1'b1;
            end
            5: begin
                m_ang[3] = (m_ang[3] != AMAX) ? AMAX : AMIN;
                m_joint = 3; m_angle = m_ang[3]; m_valid = 1'b1;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        bit busy;
        bit fire;
        started = 1'b1;
        if (rst) begin
            m_cand = 0; m_streak = 0; m_sel = 0; m_pend = -1;
            for (int j = 0; j < 4; j++) m_ang[j] = HOME;
            m_valid = 1'b0; m_joint = 0; m_angle = 0; m_drop = 1'b0;
        end else begin
            busy   = (m_pend >= 0) || m_valid;
            m_drop = gesture_valid && busy;
            if (m_pend >= 0) begin
                model_apply(m_pend);
                m_pend = -1;
            end else if (m_valid) begin
                if (cmd_ready) m_valid = 1'b0;
            end else if (gesture_valid) begin
                fire = 1'b0;
                if (int'(gesture_id) == m_cand) begin
                    if (m_streak < S) begin
                        m_streak++;
                        fire = (m_streak == S);
                    end
                end else begin
                    m_cand   = int'(gesture_id);
                    m_streak = 1;
                    fire     = (S == 1);
                end
                if (fire && m_cand >= 1 && m_cand <= 5) m_pend = m_cand;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("cyc_cmd_valid", cmd_valid, m_valid);
            if (m_valid) begin
                check("cyc_cmd_joint", cmd_joint, m_joint);
                check("cyc_cmd_angle", cmd_angle, m_angle);
            end
            check("cyc_joint_sel", joint_sel, m_sel);
            check("cyc_drop_pulse", drop_pulse, m_drop);
        end
    end

    // Record every handshake seen by the downstream.
    int n_acc = 0;
    int last_joint = -1;
    int last_angle = -1;
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            n_acc++;
            last_joint = cmd_joint;
            last_angle = cmd_angle;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [7:0] id, input int gap);
        @(posedge clk); #1;
        gesture_valid = 1'b1;
        gesture_id    = id;
        @(posedge clk); #1;
        gesture_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic pulse_n(input logic [7:0] id, input int n);
        for (int i = 0; i < n; i++) pulse(id, 3);
    endtask

    task automatic expect_cmd(input string name, input int n_before, input int j, input int a);
        check({name, "_count"}, n_acc, n_before + 1);
        check({name, "_joint"}, last_joint, j);
        check({name, "_angle"}, last_angle, a);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_seen"}, cmd_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n0;
        rst = 1'b1;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_joint", cmd_joint, 0);
        check("rst_cmd_angle", cmd_angle, 0);
        check("rst_joint_sel", joint_sel, 0);
        check("rst_drop", drop_pulse, 0);

        // Three id 2 -> one command, a held fourth does nothing.
        n0 = n_acc; pulse_n(8'd2, 3);
        expect_cmd("inc_first", n0, 0, 94);
        n0 = n_acc; pulse_n(8'd2, 1);
        check("inc_held_count", n_acc, n0);

        // Select joint 1, then decrement it.
        pulse_n(8'd1, 3);
        @(negedge clk);
        check("sel_after_next", joint_sel, 1);
        n0 = n_acc; pulse_n(8'd3, 3);
        expect_cmd("dec_j1", n0, 1, 86);

        // Home joint 1, climb to 178, then clamp at the upper limit twice.
        n0 = n_acc; pulse_n(8'd4, 3);
        expect_cmd("home_j1", n0, 1, 90);
        n0 = n_acc;
        for (int i = 0; i < 22; i++) begin
            pulse_n(8'd2, 3);
            pulse_n(8'd0, 3);
        end
        check("climb_count", n_acc, n0 + 22);
        check("climb_angle", last_angle, 178);
        n0 = n_acc; pulse_n(8'd2, 3);
        expect_cmd("clamp_max", n0, 1, 180);
        pulse_n(8'd0, 3);
        n0 = n_acc; pulse_n(8'd2, 3);
        expect_cmd("clamp_again", n0, 1, 180);

        // Grip toggle with a stalled downstream; a gesture mid-wait is dropped.
        cmd_ready = 1'b0;
        pulse_n(8'd0, 3);
        n0 = n_acc;
        pulse_n(8'd5, 3);
        wait_valid("grip");
        repeat (4) @(posedge clk);
        pulse(8'd2, 0);
        @(negedge clk);
        check("drop_mid", drop_pulse, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("grip_hold_valid", cmd_valid, 1);
        check("grip_hold_joint", cmd_joint, 3);
        check("grip_hold_angle", cmd_angle, 180);
        @(posedge clk); #1 cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        expect_cmd("grip", n0, 3, 180);
        // Dropped id 2 must not have counted toward a streak.
        n0 = n_acc; pulse_n(8'd2, 2);
        check("drop_no_streak", n_acc, n0);
        pulse_n(8'd2, 1);
        expect_cmd("after_drop", n0, 1, 180);

        // Broken streak and unused ids never produce a command.
        n0 = n_acc;
        pulse_n(8'd2, 1); pulse_n(8'd2, 1); pulse_n(8'd4, 1); pulse_n(8'd2, 1);
        check("mixed_seq_count", n_acc, n0);
        pulse_n(8'd7, 3);
        check("id7_count", n_acc, n0);
        @(negedge clk);
        check("id7_sel", joint_sel, 1);

        // Reset while a command is pending in SEND.
        cmd_ready = 1'b0;
        pulse(8'd2, 3); pulse(8'd2, 3); pulse(8'd2, 0);
        @(posedge clk); #1;
        check("send_before_rst", cmd_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_drop_valid", cmd_valid, 0);
        check("rst_sel_zero", joint_sel, 0);
        check("rst_no_handshake", n_acc, n0);

        // Angle table is back at home on every joint touched before.
        cmd_ready = 1'b1;
        n0 = n_acc; pulse_n(8'd2, 3);
        expect_cmd("post_rst_j0", n0, 0, 94);
        n0 = n_acc; pulse_n(8'd5, 3);
        expect_cmd("post_rst_grip", n0, 3, 180);
        pulse_n(8'd1, 3);
        n0 = n_acc; pulse_n(8'd3, 3);
        expect_cmd("post_rst_j1", n0, 1, 86);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gesture_cmd_sequencer.md
GESTURE_CMD_SEQUENCER -- requirements
Module: gesture_cmd_sequencer

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 3: consecutive identical valid gestures needed to qualify (legal range 1..15).
REQ-002 SHALL have parameter STEP, default 8'd4: angle increment/decrement per qualified gesture.
REQ-003 SHALL have parameters ANGLE_MIN, ANGLE_MAX and HOME_ANGLE, defaults 8'd0, 8'd180 and 8'd90: joint limits and home position.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 gesture_valid  in  1  one-cycle pulse; gesture_id is valid in that cycle.
REQ-008 gesture_id  in  8  upstream gesture code (0..5 defined).
REQ-009 cmd_valid  out  1  servo command available.
REQ-010 cmd_ready  in  1  downstream accepts the command when cmd_valid && cmd_ready.
REQ-011 cmd_joint  out  2  joint addressed by the command (3 = gripper).
REQ-012 cmd_angle  out  8  target angle for cmd_joint.
REQ-013 joint_sel  out  2  currently selected joint.
REQ-014 drop_pulse  out  1  one-cycle pulse when a gesture_valid arrives outside IDLE.

Function
REQ-015 Debounce: on each gesture_valid accepted in IDLE: if gesture_id == candidate, streak increments, saturating at STABLE_FRAMES; otherwise candidate <= gesture_id and streak <= 1.
REQ-016 A gesture qualifies only when streak transitions to STABLE_FRAMES; a held gesture does not re-fire until a different id has been accepted.
REQ-017 Actions: id 0 = none; id 1 = joint_sel <= joint_sel+1 (3 wraps to 0); id 2 = angle[joint_sel] + STEP; id 3 = angle[joint_sel] - STEP; id 4 = angle[joint_sel] <= HOME_ANGLE; id 5 = angle[3] toggles (ANGLE_MAX if currently != ANGLE_MAX, else ANGLE_MIN).
REQ-018 Ids greater than 5 SHALL take part in debouncing, but SHALL never cause an action or a command.
REQ-019 Arithmetic is 9-bit: increment clamps to ANGLE_MAX and decrement clamps to ANGLE_MIN; a command is still issued when the value is already at its limit.
REQ-020 FSM states: IDLE, EXEC, SEND.
REQ-021 FSM transitions: IDLE->EXEC on qualification of ids 1..5; EXEC->SEND for ids 2..5; EXEC->IDLE for id 1; SEND->IDLE on the cycle cmd_valid && cmd_ready.
REQ-022 Latency: a gesture qualifying at edge N SHALL update the angle table, cmd_joint and cmd_angle at edge N+1, with cmd_valid high from edge N+1.
REQ-023 cmd_joint and cmd_angle SHALL be held stable while cmd_valid=1 && cmd_ready=0; cmd_valid deasserts on the edge after acceptance.
REQ-024 In EXEC or SEND, gesture_valid SHALL be discarded: debouncer state is unchanged and drop_pulse=1 on the next cycle.
REQ-025 cmd_ready asserted in IDLE or EXEC has no effect.

Reset
REQ-026 While rst=1 at an edge: state=IDLE, angle[0..3]=HOME_ANGLE, joint_sel=0, candidate=0, streak=0, cmd_valid=0, cmd_joint=0, cmd_angle=0, drop_pulse=0.
REQ-027 Reset during SEND SHALL drop the pending command without handshake; cmd_valid=0 in the cycle after the reset edge.

Structure
REQ-028 Gesture id constants, FSM state encoding and HOME_ANGLE default SHALL live in shared package gesture_pkg.
REQ-029 Debounce logic (REQ-015/016) SHALL be the sub-module gesture_debouncer, outputting a one-cycle qualify pulse and the qualified id.
REQ-030 The angle table SHALL be 4 x 8-bit registers, not RAM.

Verification
REQ-031 Pulse id 2 three times, cmd_ready=1 -> single cmd: joint 0, angle 94; a fourth id 2 yields no command.
REQ-032 Pulse id 1 x3, then id 3 x3 -> joint_sel=1, cmd: joint 1, angle 86.
REQ-033 Starting at angle 178, qualify id 2 -> cmd_angle 180; repeat the qualification via intervening id 0 x3 -> cmd_angle 180 again.
REQ-034 Qualify id 5 with cmd_ready=0 for 10 cycles -> cmd_valid held with joint 3, angle 180; pulse gesture_valid mid-wait -> drop_pulse=1 and no streak change.
REQ-035 Sequence id 2, id 2, id 4, id 2 -> no command; id 7 x3 -> no command; id 2 x3 then rst in SEND -> cmd_valid=0 next cycle and all angles 90.
